// File: rtl/cache_arbiter.sv
// Cache arbiter: shares one burst-oriented memory port between an I-cache and
// a D-cache. Each requester moves whole lines; the memory side moves them as
// BURST_LEN beats of BEAT_W bits. Ties alternate, starting with the D-cache.
module cache_arbiter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        i_read,
    input  logic                        i_write,
    input  logic [31:0]                 i_address,
    input  logic [BEAT_W*BURST_LEN-1:0] i_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
    output logic                        i_resp,

    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [31:0]                 d_address,
    input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
    output logic                        d_resp,

    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [31:0]                 pmem_address,
    output logic [BEAT_W-1:0]           pmem_wdata,
    input  logic [BEAT_W-1:0]           pmem_rdata,
    input  logic                        pmem_resp
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BURST_LEN - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  beat;
    logic              grant_d;       // 1: current transaction belongs to the D-cache
    logic              last_grant_d;  // 1: previous completed transaction was the D-cache
    logic              op_write;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_buf;

    logic i_pend;
    logic d_pend;
    logic pick_d;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        // NOTE: default first so every path assigns pick_d and no latch is inferred.
        pick_d = 1'b0;
        if (i_pend && d_pend) begin
            pick_d = ~last_grant_d;
        end else begin
            pick_d = d_pend;
        end
    end

    // Control FSM: sequencing, beat counting and the registered memory commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat         <= '0;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (i_pend || d_pend) begin
                        grant_d <= pick_d;
                        beat    <= '0;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    pmem_write <= op_write;
                    pmem_read  <= ~op_write;
                    state      <= op_write ? ST_WRITE : ST_READ;
                end
                ST_READ, ST_WRITE: begin
                    if (pmem_resp) begin
                        if (beat == BEAT_LAST) begin
                            beat       <= '0;
                            pmem_read  <= 1'b0;
                            pmem_write <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    last_grant_d <= grant_d;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: capture the winner's request at grant, assemble read beats into the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            // NOTE: the line buffer is reset because it is visible on rdata after reset.
            line_buf <= '0;
        end else begin
            if (state == ST_IDLE && (i_pend || d_pend)) begin
                addr_q   <= pick_d ? d_address : i_address;
                wdata_q  <= pick_d ? d_wdata   : i_wdata;
                op_write <= pick_d ? d_write   : i_write;
            end
            if (state == ST_READ && pmem_resp) begin
                line_buf[beat*BEAT_W +: BEAT_W] <= pmem_rdata;
            end
        end
    end

    assign pmem_address = addr_q & 32'hFFFF_FFE0;
    assign pmem_wdata   = wdata_q[beat*BEAT_W +: BEAT_W];

    assign i_resp  = (state == ST_DONE) && !grant_d;
    assign d_resp  = (state == ST_DONE) &&  grant_d;
    assign i_rdata = line_buf;
    assign d_rdata = line_buf;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single reads/writes, tie arbitration,
// alternation, mid-burst reset and stray/dropped handshakes.
module tb_cache_arbiter;

    localparam int BEAT_W = 64;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_read = 1'b0, i_write = 1'b0;
    logic [31:0]       i_address = '0;
    logic [LINE_W-1:0] i_wdata = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0, d_write = 1'b0;
    logic [31:0]       d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read, pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    cache_arbiter #(.BEAT_W(BEAT_W), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_address(i_address),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    // Waits (bounded) for a memory command, then plays nbeats back-to-back beats.
    // For a full burst, checks the DONE cycle outputs on return.
    task automatic burst(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [31:0] exp_addr, input logic [LINE_W-1:0] line,
                         input int nbeats, input bit drop_mid,
                         input logic [LINE_W-1:0] exp_rdata, output int lat);
        lat = 0;
        while (!(pmem_read || pmem_write) && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_cmd_seen"}, LINE_W'(pmem_read | pmem_write), 1);
        if (!(pmem_read || pmem_write)) return;
        check({tag, "_addr"}, LINE_W'(pmem_address), LINE_W'(exp_addr));
        for (int b = 0; b < nbeats; b++) begin
            check({tag, "_cmd_held"}, LINE_W'({pmem_read, pmem_write}),
                  exp_wr ? LINE_W'(2'b01) : LINE_W'(2'b10));
            check({tag, "_resp_idle"}, LINE_W'({i_resp, d_resp}), 0);
            if (exp_wr) check({tag, "_wbeat"}, LINE_W'(pmem_wdata), LINE_W'(line[b*BEAT_W +: BEAT_W]));
            pmem_rdata = line[b*BEAT_W +: BEAT_W];
            pmem_resp  = 1'b1;
            @(negedge clk);
            if (drop_mid && b == 0) begin
                if (exp_d) begin d_read = 1'b0; d_write = 1'b0; end
                else       begin i_read = 1'b0; i_write = 1'b0; end
            end
        end
        pmem_resp = 1'b0;
        if (nbeats == 4) begin
            check({tag, "_resp"}, LINE_W'({i_resp, d_resp}), exp_d ? LINE_W'(2'b01) : LINE_W'(2'b10));
            check({tag, "_cmd_drop"}, LINE_W'({pmem_read, pmem_write}), 0);
            check({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, exp_rdata);
        end
    endtask

    initial begin
        int lat;
        logic [LINE_W-1:0] line1, line2, line3, line4, wline;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd", LINE_W'({pmem_read, pmem_write}), 0);
        check("rst_resp", LINE_W'({i_resp, d_resp}), 0);
        check("rst_addr", LINE_W'(pmem_address), 0);
        check("rst_wdata", LINE_W'(pmem_wdata), 0);
        check("rst_rdata", d_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // D-cache read, address aligned down, beats assembled low-first
        line1 = mk_line(64'hA0);
        d_read = 1'b1; d_address = 32'h0000_1234;
        burst("dread", 1'b1, 1'b0, 32'h0000_1220, line1, 4, 1'b0, line1, lat);
        check("dread_lat", LINE_W'(lat), 2);
        d_read = 1'b0;
        @(negedge clk);
        check("dread_once", LINE_W'(d_resp), 0);

        // I-cache write: beats 0x11..0x44, buffer unchanged on rdata
        wline = {64'h44, 64'h33, 64'h22, 64'h11};
        i_write = 1'b1; i_wdata = wline; i_address = 32'h0000_5678;
        burst("iwrite", 1'b0, 1'b1, 32'h0000_5660, wline, 4, 1'b0, line1, lat);
        i_write = 1'b0;
        @(negedge clk);

        // Tie after reset: D first, then I; command low between bursts
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        line2 = mk_line(64'hC0);
        i_read = 1'b1; i_address = 32'h0000_2000;
        d_read = 1'b1; d_address = 32'h0000_3010;
        burst("tie_d", 1'b1, 1'b0, 32'h0000_3000, line2, 4, 1'b0, line2, lat);
        d_read = 1'b0;
        @(negedge clk);
        check("tie_gap_idle", LINE_W'({pmem_read, pmem_write}), 0);
        @(negedge clk);
        check("tie_gap_grant", LINE_W'({pmem_read, pmem_write}), 0);
        burst("tie_i", 1'b0, 1'b0, 32'h0000_2000, mk_line(64'hD0), 4, 1'b0, mk_line(64'hD0), lat);
        i_read = 1'b0;
        @(negedge clk);

        // Continuous re-requests: grants alternate D, I, D, I, D, I
        i_read = 1'b1; d_read = 1'b1;
        d_address = 32'h0000_4040; i_address = 32'h0000_8000;
        for (int k = 0; k < 6; k++) begin
            bit is_d;
            is_d = (k % 2 == 0);
            burst($sformatf("alt%0d", k), is_d, 1'b0, is_d ? 32'h0000_4040 : 32'h0000_8000,
                  mk_line(64'h100 * (k + 1)), 4, 1'b0, mk_line(64'h100 * (k + 1)), lat);
            if (k == 5) begin
                i_read = 1'b0; d_read = 1'b0;
            end else begin
                if (is_d) d_read = 1'b0; else i_read = 1'b0;
                @(negedge clk);
                if (is_d) d_read = 1'b1; else i_read = 1'b1;
            end
        end
        @(negedge clk);

        // Reset after the 2nd read beat aborts the burst
        d_read = 1'b1; d_address = 32'h0000_7777;
        burst("abort", 1'b1, 1'b0, 32'h0000_7760, mk_line(64'hE0), 2, 1'b0, '0, lat);
        rst = 1'b1;
        #1;
        check("abort_async_drop", LINE_W'({pmem_read, pmem_write}), 0);
        check("abort_no_resp", LINE_W'({i_resp, d_resp}), 0);
        @(negedge clk);
        d_read = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", LINE_W'({pmem_read, pmem_write}), 0);
        check("abort_buf_clr", d_rdata, 0);
        line3 = mk_line(64'hF0);
        d_read = 1'b1; d_address = 32'h0000_0100;
        burst("after_rst", 1'b1, 1'b0, 32'h0000_0100, line3, 4, 1'b0, line3, lat);
        d_read = 1'b0;
        @(negedge clk);

        // Stray pmem_resp in IDLE is ignored; dropped request still completes once
        pmem_rdata = 64'hDEAD; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        check("stray_cmd", LINE_W'({pmem_read, pmem_write}), 0);
        check("stray_resp", LINE_W'({i_resp, d_resp}), 0);
        check("stray_buf", d_rdata, line3);
        line4 = mk_line(64'h50);
        d_read = 1'b1; d_address = 32'h0000_9000;
        burst("drop_mid", 1'b1, 1'b0, 32'h0000_9000, line4, 4, 1'b1, line4, lat);
        @(negedge clk);
        check("drop_mid_once", LINE_W'({i_resp, d_resp}), 0);
        check("drop_mid_idle", LINE_W'({pmem_read, pmem_write}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter BEAT_W, default 64: width of one memory burst beat in bits.
REQ-002 Parameter BURST_LEN, default 4: beats per cache line; line width LINE_W = BEAT_W*BURST_LEN, 256 by default.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_read, i_write  input  1 each  I-cache line read / write request, held until i_resp.
REQ-006 i_address  input  32  I-cache line address.
REQ-007 i_wdata  input  LINE_W  I-cache line write data.
REQ-008 i_rdata  output  LINE_W  I-cache line read data.
REQ-009 i_resp  output  1  I-cache completion pulse.
REQ-010 d_read, d_write, d_address, d_wdata, d_rdata, d_resp  same directions, widths and meanings as the i_* ports, for the D-cache.
REQ-011 pmem_read, pmem_write  output  1 each  burst memory read / write command.
REQ-012 pmem_address  output  32  line-aligned burst address.
REQ-013 pmem_wdata  output  BEAT_W  current write beat.
REQ-014 pmem_rdata  input  BEAT_W  current read beat.
REQ-015 pmem_resp  input  1  one pulse per completed beat.

Function
REQ-016 FSM states: IDLE, GRANT, READ, WRITE, DONE.
REQ-017 IDLE, no request pending: stay in IDLE.
REQ-018 IDLE, exactly one requester pending: grant that requester and go to GRANT.
REQ-019 IDLE, both requesters pending: grant the requester not granted last; the last-grant flag resets to I-cache, so the first tie goes to the D-cache.
REQ-020 At grant: latch the requester's address, wdata and operation into internal registers, and clear the 2-bit beat counter.
REQ-021 Operation selection: write takes precedence over read if both are asserted by the same requester.
REQ-022 GRANT lasts one cycle, then goes to READ or WRITE; pmem_read/pmem_write therefore rise on the second cycle after the request is first seen in IDLE.
REQ-023 pmem_address = {latched_address[31:5], 5'b0}; it is held constant while pmem_read or pmem_write is high.
REQ-024 pmem_read/pmem_write are registered and held high from entry to READ/WRITE until the cycle of the final pmem_resp.
REQ-025 Both deassert on the edge after the final pmem_resp; at most one of pmem_read/pmem_write is ever high.
REQ-026 WRITE: pmem_wdata = latched wdata[beat*BEAT_W +: BEAT_W], beat 0 first; each pmem_resp increments the beat counter.
REQ-027 READ: on each pmem_resp, store pmem_rdata into line-buffer slot [beat*BEAT_W +: BEAT_W], then increment the beat counter.
REQ-028 On the pmem_resp where beat == BURST_LEN-1, go to DONE; the counter wraps to 0.
REQ-029 DONE lasts exactly one cycle: the granted requester's resp is high, and its rdata holds the assembled line (read) or the unchanged buffer (write).
REQ-030 After DONE: update the last-grant flag, return to IDLE, and evaluate the next arbitration in the following cycle.
REQ-031 Requester handshake: requesters deassert read/write in the cycle after their resp. The arbiter never re-grants a requester during its own DONE cycle.
REQ-032 A request dropped mid-transaction is ignored: the burst completes and resp still pulses.
REQ-033 pmem_resp outside READ/WRITE is ignored.
REQ-034 The non-granted requester's resp stays low throughout; its request remains pending and is served next.
REQ-035 i_rdata and d_rdata both drive the shared line buffer; each is valid only while its own resp is high.

Reset
REQ-036 rst high: state=IDLE, beat counter=0, last-grant=I-cache, line buffer=0, latched address/wdata=0; every output is 0.
REQ-037 A reset mid-burst aborts the transaction: pmem_read/pmem_write drop asynchronously, no resp is issued, and requesters must re-request after reset.

Verification
REQ-038 d_read, d_address=0x0000_1234, four pmem_resp beats 0xA0..0xA3 -> pmem_read high 2 cycles after the request; pmem_address=0x0000_1220; d_resp 1 cycle after the 4th beat; d_rdata={0xA3,0xA2,0xA1,0xA0}; i_resp stays 0.
REQ-039 i_write, i_wdata={0x44,0x33,0x22,0x11} (64-bit beats) -> pmem_wdata sequences 0x11,0x22,0x33,0x44, one per pmem_resp; i_resp 1 cycle after the last beat.
REQ-040 i_read and d_read both asserted in the same cycle after reset -> D-cache served first, then I-cache; pmem_read stays high continuously within each burst and is low between bursts.
REQ-041 Both requesters continuously re-requesting across 6 transactions -> grants alternate D, I, D, I, D, I.
REQ-042 rst asserted after the 2nd read beat -> pmem_read drops asynchronously; no resp; after reset a new d_read completes normally with the beat count starting at 0.
REQ-043 pmem_resp pulsed in IDLE, and requester dropping d_read mid-burst -> stray pmem_resp has no effect; the burst completes and d_resp pulses once.
